// File: rtl/uart_rx_engine.sv
// UART receive engine: synchronises rx, recovers 7/8-bit frames with optional parity,
// and presents the byte plus parity/framing/overrun status until the host reads it.
module uart_rx_engine #(
    parameter int SYNC_STAGES = 2,
    parameter int KW          = 19
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          rx,
    input  logic          eight,
    input  logic          pen,
    input  logic          ohel,
    input  logic [KW-1:0] baud_k,
    input  logic          rd_clr,
    output logic [7:0]    rx_data,
    output logic          rxrdy,
    output logic          perr,
    output logic          ferr,
    output logic          ovf
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_DATA  = 3'd2,
        S_PAR   = 3'd3,
        S_STOP  = 3'd4,
        S_DONE  = 3'd5
    } state_e;

    function automatic logic parity8(input logic [7:0] v);
        return ^v;
    endfunction

    localparam logic [KW-1:0] CNT_ONE = {{(KW-1){1'b0}}, 1'b1};

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   rxs_s;
    logic                   rxs_prev_q;
    state_e                 state_q, state_d;
    logic [KW-1:0]          cnt_q, cnt_d;
    logic [KW-1:0]          baud_q, baud_d;
    logic [2:0]             bit_q, bit_d;
    logic [7:0]             shreg_q, shreg_d;
    logic                   par_q, par_d;
    logic                   stop_q, stop_d;
    logic                   eight_q, eight_d;
    logic                   pen_q, pen_d;
    logic                   ohel_q, ohel_d;
    logic [7:0]             rx_data_q, rx_data_d;
    logic                   rxrdy_q, rxrdy_d;
    logic                   perr_q, perr_d;
    logic                   ferr_q, ferr_d;
    logic                   ovf_q, ovf_d;
    logic                   expire_s;
    logic                   last_bit_s;
    logic [7:0]             data_s;
    logic                   exp_par_s;

    // Input synchroniser; the previous synchronised level gates start detection
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q     <= {SYNC_STAGES{1'b1}};
            rxs_prev_q <= 1'b1;
        end else begin
            sync_q     <= {sync_q[SYNC_STAGES-2:0], rx};
            rxs_prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign rxs_s      = sync_q[SYNC_STAGES-1];
    assign expire_s   = (cnt_q == CNT_ONE);
    assign last_bit_s = eight_q ? (bit_q == 3'd7) : (bit_q == 3'd6);
    assign data_s     = eight_q ? shreg_q : {1'b0, shreg_q[7:1]};
    assign exp_par_s  = ohel_q ? ~parity8(data_s) : parity8(data_s);

    // Frame FSM next-state, bit sampling and output load
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        baud_d    = baud_q;
        bit_d     = bit_q;
        shreg_d   = shreg_q;
        par_d     = par_q;
        stop_d    = stop_q;
        eight_d   = eight_q;
        pen_d     = pen_q;
        ohel_d    = ohel_q;
        rx_data_d = rx_data_q;
        perr_d    = perr_q;
        ferr_d    = ferr_q;
        case (state_q)
            S_IDLE: begin
                // A falling edge is required, so a held break cannot restart frames
                if (!rxs_s && rxs_prev_q) begin
                    state_d = S_START;
                    bit_d   = 3'd0;
                    cnt_d   = baud_k >> 1;
                    baud_d  = baud_k;
                    eight_d = eight;
                    pen_d   = pen;
                    ohel_d  = ohel;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_START: begin
                if (expire_s) begin
                    if (rxs_s) begin
                        state_d = S_IDLE;
                    end else begin
                        state_d = S_DATA;
                        cnt_d   = baud_q;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            S_DATA: begin
                if (expire_s) begin
                    shreg_d = {rxs_s, shreg_q[7:1]};
                    bit_d   = bit_q + 3'd1;
                    cnt_d   = baud_q;
                    if (last_bit_s) begin
                        state_d = pen_q ? S_PAR : S_STOP;
                    end else begin
                        state_d = S_DATA;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            S_PAR: begin
                if (expire_s) begin
                    par_d   = rxs_s;
                    cnt_d   = baud_q;
                    state_d = S_STOP;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            S_STOP: begin
                if (expire_s) begin
                    stop_d  = rxs_s;
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            S_DONE: begin
                rx_data_d = data_s;
                perr_d    = pen_q & (par_q != exp_par_s);
                ferr_d    = ~stop_q;
                cnt_d     = {KW{1'b0}};
                state_d   = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Ready/overrun handshake: a completing frame takes priority over a host read
    always_comb begin
        rxrdy_d = rxrdy_q;
        ovf_d   = ovf_q;
        if (state_q == S_DONE) begin
            rxrdy_d = 1'b1;
            ovf_d   = ovf_q | (rxrdy_q & ~rd_clr);
        end else if (rd_clr) begin
            rxrdy_d = 1'b0;
            ovf_d   = 1'b0;
        end else begin
            rxrdy_d = rxrdy_q;
            ovf_d   = ovf_q;
        end
    end

    // State and output registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            cnt_q     <= {KW{1'b0}};
            baud_q    <= {KW{1'b0}};
            bit_q     <= 3'd0;
            shreg_q   <= 8'd0;
            par_q     <= 1'b0;
            stop_q    <= 1'b0;
            eight_q   <= 1'b0;
            pen_q     <= 1'b0;
            ohel_q    <= 1'b0;
            rx_data_q <= 8'd0;
            rxrdy_q   <= 1'b0;
            perr_q    <= 1'b0;
            ferr_q    <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            baud_q    <= baud_d;
            bit_q     <= bit_d;
            shreg_q   <= shreg_d;
            par_q     <= par_d;
            stop_q    <= stop_d;
            eight_q   <= eight_d;
            pen_q     <= pen_d;
            ohel_q    <= ohel_d;
            rx_data_q <= rx_data_d;
            rxrdy_q   <= rxrdy_d;
            perr_q    <= perr_d;
            ferr_q    <= ferr_d;
            ovf_q     <= ovf_d;
        end
    end

    assign rx_data = rx_data_q;
    assign rxrdy   = rxrdy_q;
    assign perr    = perr_q;
    assign ferr    = ferr_q;
    assign ovf     = ovf_q;

endmodule

// File: tb/tb_uart_rx_engine.sv
// Bench for uart_rx_engine: frames are built bit by bit on rx, expected status is queued
// at send time and compared once the frame has been fully delivered.
module tb_uart_rx_engine;

    localparam int KW = 19;

    logic          clk = 1'b0;
    logic          reset;
    logic          rx;
    logic          eight;
    logic          pen;
    logic          ohel;
    logic [KW-1:0] baud_k;
    logic          rd_clr;
    logic [7:0]    rx_data;
    logic          rxrdy;
    logic          perr;
    logic          ferr;
    logic          ovf;

    typedef struct {
        logic [7:0] data;
        logic       rdy;
        logic       pe;
        logic       fe;
        logic       ov;
    } exp_t;

    exp_t sb_q[$];
    int   errors = 0;
    int   checks = 0;
    logic rxrdy_m = 1'b0;
    logic ovf_m   = 1'b0;

    uart_rx_engine #(.SYNC_STAGES(2), .KW(KW)) dut (
        .clk     (clk),
        .reset   (reset),
        .rx      (rx),
        .eight   (eight),
        .pen     (pen),
        .ohel    (ohel),
        .baud_k  (baud_k),
        .rd_clr  (rd_clr),
        .rx_data (rx_data),
        .rxrdy   (rxrdy),
        .perr    (perr),
        .ferr    (ferr),
        .ovf     (ovf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drive one frame; with clr_done set, rd_clr is pulsed on the frame's completion edge.
    task automatic send_frame(input logic [7:0] d, input int nd, input logic p,
                              input logic pb, input logic sb, input logic clr_done);
        logic [10:0] fr;
        int          nbits;
        int          k;
        int          c_done;
        exp_t        e;
        k      = int'(baud_k);
        nbits  = 2 + nd + int'(p);
        fr     = 11'h7FF;
        fr[0]  = 1'b0;
        for (int i = 0; i < nd; i++) fr[1+i] = d[i];
        if (p) fr[1+nd] = pb;
        fr[1+nd+int'(p)] = sb;
        // Completion edge: two sync flops, one IDLE cycle, half a bit, then nd+p+1 bits, then DONE
        c_done = 3 + k / 2 + (nd + 1 + int'(p)) * k;
        e.data = (nd == 7) ? {1'b0, d[6:0]} : d;
        e.pe   = p && ((($countones(e.data) + int'(pb)) % 2 == 1) != ohel);
        e.fe   = ~sb;
        if (!clr_done) ovf_m = ovf_m | rxrdy_m;
        rxrdy_m = 1'b1;
        e.rdy   = rxrdy_m;
        e.ov    = ovf_m;
        sb_q.push_back(e);
        for (int c = 0; c < nbits * k; c++) begin
            @(negedge clk);
            rx     = fr[c/k];
            rd_clr = (clr_done && (c == c_done)) ? 1'b1 : 1'b0;
        end
        @(negedge clk);
        rx     = 1'b1;
        rd_clr = 1'b0;
    endtask

    task automatic check_frame(input string tag);
        exp_t e;
        repeat (2) @(negedge clk);
        chk({tag, "_pending"}, sb_q.size(), 32'd1);
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            chk({tag, "_data"},  {24'd0, rx_data}, {24'd0, e.data});
            chk({tag, "_rxrdy"}, {31'd0, rxrdy},   {31'd0, e.rdy});
            chk({tag, "_perr"},  {31'd0, perr},    {31'd0, e.pe});
            chk({tag, "_ferr"},  {31'd0, ferr},    {31'd0, e.fe});
            chk({tag, "_ovf"},   {31'd0, ovf},     {31'd0, e.ov});
        end
    endtask

    task automatic pulse_clr(input string tag);
        @(negedge clk);
        rd_clr = 1'b1;
        @(negedge clk);
        rd_clr  = 1'b0;
        rxrdy_m = 1'b0;
        ovf_m   = 1'b0;
        @(negedge clk);
        chk({tag, "_clr_rxrdy"}, {31'd0, rxrdy}, {31'd0, rxrdy_m});
        chk({tag, "_clr_ovf"},   {31'd0, ovf},   {31'd0, ovf_m});
    endtask

    initial begin
        logic [7:0] pd;
        reset  = 1'b1;
        rx     = 1'b1;
        rd_clr = 1'b0;
        eight  = 1'b1;
        pen    = 1'b0;
        ohel   = 1'b0;
        baud_k = 19'd868;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_data",  {24'd0, rx_data}, 32'd0);
        chk("rst_rxrdy", {31'd0, rxrdy},   32'd0);
        chk("rst_perr",  {31'd0, perr},    32'd0);
        chk("rst_ferr",  {31'd0, ferr},    32'd0);
        chk("rst_ovf",   {31'd0, ovf},     32'd0);

        // 8N1 at full baud divisor
        send_frame(8'hA5, 8, 1'b0, 1'b0, 1'b1, 1'b0);
        check_frame("8n1_a5");
        pulse_clr("8n1_a5");

        // 7E1, correct then wrong parity
        baud_k = 19'd32;
        eight  = 1'b0;
        pen    = 1'b1;
        ohel   = 1'b0;
        send_frame(8'h41, 7, 1'b1, 1'b0, 1'b1, 1'b0);
        check_frame("7e1_ok");
        pulse_clr("7e1_ok");
        send_frame(8'h41, 7, 1'b1, 1'b1, 1'b1, 1'b0);
        check_frame("7e1_bad");
        pulse_clr("7e1_bad");

        // 8O1 with a bad stop bit, then a clean frame
        eight = 1'b1;
        ohel  = 1'b1;
        send_frame(8'h00, 8, 1'b1, 1'b1, 1'b0, 1'b0);
        check_frame("8o1_ferr");
        pulse_clr("8o1_ferr");
        send_frame(8'h37, 8, 1'b1, 1'b0, 1'b1, 1'b0);
        check_frame("8o1_ok");

        // Overrun: second frame arrives unread
        pen  = 1'b0;
        ohel = 1'b0;
        send_frame(8'h11, 8, 1'b0, 1'b0, 1'b1, 1'b0);
        check_frame("ovr_11");
        send_frame(8'h22, 8, 1'b0, 1'b0, 1'b1, 1'b0);
        check_frame("ovr_22");
        pulse_clr("ovr_22");

        // Host read on the completion edge: set wins, no overrun
        send_frame(8'h33, 8, 1'b0, 1'b0, 1'b1, 1'b0);
        check_frame("clr_33");
        send_frame(8'h44, 8, 1'b0, 1'b0, 1'b1, 1'b1);
        check_frame("clr_44");
        pulse_clr("clr_44");

        // Short low glitch must not produce a byte
        baud_k = 19'd868;
        @(negedge clk);
        rx = 1'b0;
        repeat (100) @(negedge clk);
        rx = 1'b1;
        repeat (1000) @(negedge clk);
        chk("glitch_rxrdy", {31'd0, rxrdy}, {31'd0, rxrdy_m});
        chk("glitch_data",  {24'd0, rx_data}, 32'h44);

        // Reset in the middle of data bit 4, then a clean frame
        baud_k = 19'd32;
        send_frame(8'hC3, 8, 1'b0, 1'b0, 1'b1, 1'b0);
        check_frame("pre_rst_c3");
        pd = 8'h5A;
        @(negedge clk);
        rx = 1'b0;
        for (int c = 0; c < 5 * 32 + 16; c++) begin
            @(negedge clk);
            rx = (c < 32) ? 1'b0 : pd[c/32 - 1];
        end
        @(negedge clk);
        reset = 1'b1;
        #1;
        rxrdy_m = 1'b0;
        ovf_m   = 1'b0;
        chk("midrst_data",  {24'd0, rx_data}, 32'd0);
        chk("midrst_rxrdy", {31'd0, rxrdy},   32'd0);
        chk("midrst_perr",  {31'd0, perr},    32'd0);
        chk("midrst_ferr",  {31'd0, ferr},    32'd0);
        chk("midrst_ovf",   {31'd0, ovf},     32'd0);
        rx = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (5) @(negedge clk);
        send_frame(8'h5A, 8, 1'b0, 1'b0, 1'b1, 1'b0);
        check_frame("post_rst_5a");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
